// File: rtl/multiplicador_ctrl_if.sv
// Control bundle between the shift-add multiplier datapath and its sequencer.
// The master side is the datapath plus the requester; the slave side is the sequencer.
interface multiplicador_ctrl_if;
    logic       start;
    logic       b_lsb;
    logic       a_sel;
    logic       b_sel;
    logic       prod_sel;
    logic       add_sel;
    logic       busy;
    logic       done;
    logic [5:0] count;

    modport master (
        output start,
        output b_lsb,
        input  a_sel,
        input  b_sel,
        input  prod_sel,
        input  add_sel,
        input  busy,
        input  done,
        input  count
    );

    modport slave (
        input  start,
        input  b_lsb,
        output a_sel,
        output b_sel,
        output prod_sel,
        output add_sel,
        output busy,
        output done,
        output count
    );
endinterface

// File: rtl/multiplicador_ctrl.sv
// Sequencer for the shift-add multiplier: one LOAD cycle, N_BITS add/shift
// iterations, then a single-cycle DONE pulse while the product is final.
module multiplicador_ctrl #(
    parameter int N_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    multiplicador_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [5:0] LAST_CNT = 6'(N_BITS - 1);

    state_e     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic       a_sel_q;
    logic       b_sel_q;
    logic       prod_sel_q;
    logic       run_q;
    logic       busy_q;
    logic       done_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
                count_d = '0;
            end
            RUN: begin
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + 6'd1;
                end
            end
            DONE: begin
                state_d = bus.start ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            a_sel_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            prod_sel_q <= 1'b1;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            a_sel_q    <= (state_d == RUN);
            b_sel_q    <= (state_d == RUN);
            prod_sel_q <= (state_d != LOAD);
            run_q      <= (state_d == RUN);
            busy_q     <= (state_d == LOAD) || (state_d == RUN);
            done_q     <= (state_d == DONE);
        end
    end

    assign bus.a_sel    = a_sel_q;
    assign bus.b_sel    = b_sel_q;
    assign bus.prod_sel = prod_sel_q;
    // Mealy path: add when the current multiplier bit is set, hold otherwise.
    assign bus.add_sel  = run_q ? ~bus.b_lsb : 1'b1;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;

endmodule

// File: tb/tb_multiplicador_ctrl.sv
// Bench for multiplicador_ctrl: a shift-add datapath model feeds b_lsb back,
// and a scoreboard holds the expected product and done cycle per request.
module tb_multiplicador_ctrl;

    logic clk;
    logic reset;
    logic b4_lsb;

    multiplicador_ctrl_if bus32 ();
    multiplicador_ctrl_if bus4 ();

    multiplicador_ctrl #(.N_BITS(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    multiplicador_ctrl #(.N_BITS(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    int          cyc_q[$];

    logic [63:0] a_op;
    logic [31:0] b_op;
    logic [63:0] A_q;
    logic [31:0] B_q;
    logic [63:0] prod_q;

    localparam logic [11:0] IDLE_V = {1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [11:0] LOAD_V = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [11:0] DONE_V = {1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-add datapath model driven by the controller's selects.
    always @(posedge clk) begin
        A_q    <= bus32.a_sel ? (A_q << 1) : a_op;
        B_q    <= bus32.b_sel ? (B_q >> 1) : b_op;
        prod_q <= !bus32.prod_sel ? 64'd0 : (bus32.add_sel ? prod_q : prod_q + A_q);
    end

    assign bus32.b_lsb = B_q[0];
    assign bus4.b_lsb  = b4_lsb;

    function automatic logic [11:0] pk(input logic busy, input logic done, input logic [5:0] cnt,
                                       input logic a, input logic b, input logic p, input logic add);
        return {busy, done, cnt, a, b, p, add};
    endfunction

    function automatic logic [11:0] act32();
        return {bus32.busy, bus32.done, bus32.count, bus32.a_sel, bus32.b_sel, bus32.prod_sel, bus32.add_sel};
    endfunction

    function automatic logic [11:0] act4();
        return {bus4.busy, bus4.done, bus4.count, bus4.a_sel, bus4.b_sel, bus4.prod_sel, bus4.add_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus32.start = 1'b0;
        bus4.start = 1'b0;
        tick();
        tick();
        vectors++;
        if (act32() !== IDLE_V) begin
            miscompares++;
            $display("FAIL reset_hold got=%h exp=%h", act32(), IDLE_V);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (act32() !== IDLE_V || act4() !== IDLE_V) begin
                miscompares++;
                $display("FAIL reset_idle i=%0d got32=%h got4=%h exp=%h", i, act32(), act4(), IDLE_V);
            end
        end
    endtask

    task automatic test_single();
        logic [11:0] e;
        logic [63:0] ep;
        int          ec;
        int          k;
        a_op = 64'd3;
        b_op = 32'h0000_0005;
        bus32.start = 1'b1;
        exp_q.push_back(64'h0000_0000_0000_000F);
        cyc_q.push_back(34);
        tick();
        bus32.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            k = cyc - 2;
            if (cyc == 1) e = LOAD_V;
            else if (cyc <= 33) e = pk(1'b1, 1'b0, 6'(k), 1'b1, 1'b1, 1'b1, !(k == 0 || k == 2));
            else if (cyc == 34) e = DONE_V;
            else e = IDLE_V;
            vectors++;
            if (act32() !== e) begin
                miscompares++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, act32(), e);
            end
            if (bus32.done === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL single_sb unexpected done at cyc=%0d", cyc);
                end else begin
                    ep = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    if (prod_q !== ep || cyc != ec) begin
                        miscompares++;
                        $display("FAIL single_sb prod=%h exp=%h cyc=%0d exp=%0d", prod_q, ep, cyc, ec);
                    end
                end
            end
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_drain pending=%0d exp=0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        logic [63:0] ep;
        int          ec;
        int          ph;
        a_op = 64'd7;
        b_op = 32'h0000_0009;
        bus32.start = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            exp_q.push_back(64'd63);
            cyc_q.push_back(34 * n);
        end
        tick();
        for (int cyc = 1; cyc <= 108; cyc++) begin
            ph = (cyc - 1) % 34;
            if (cyc > 102) e = IDLE_V;
            else if (ph == 0) e = LOAD_V;
            else if (ph <= 32) e = pk(1'b1, 1'b0, 6'(ph - 1), 1'b1, 1'b1, 1'b1, !(ph == 1 || ph == 4));
            else e = DONE_V;
            vectors++;
            if (act32() !== e) begin
                miscompares++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, act32(), e);
            end
            if (bus32.done === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_sb unexpected done at cyc=%0d", cyc);
                end else begin
                    ep = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    if (prod_q !== ep || cyc != ec) begin
                        miscompares++;
                        $display("FAIL b2b_sb prod=%h exp=%h cyc=%0d exp=%0d", prod_q, ep, cyc, ec);
                    end
                end
            end
            if (cyc == 102) bus32.start = 1'b0;
            tick();
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain pending=%0d exp=0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_start_ignored();
        logic [11:0] e;
        logic [63:0] ep;
        int          ec;
        int          k;
        int          dones;
        dones = 0;
        a_op = 64'd3;
        b_op = 32'h0000_0005;
        bus32.start = 1'b1;
        exp_q.push_back(64'd15);
        cyc_q.push_back(34);
        tick();
        bus32.start = 1'b0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            k = cyc - 2;
            if (cyc == 1) e = LOAD_V;
            else if (cyc <= 33) e = pk(1'b1, 1'b0, 6'(k), 1'b1, 1'b1, 1'b1, !(k == 0 || k == 2));
            else if (cyc == 34) e = DONE_V;
            else e = IDLE_V;
            vectors++;
            if (act32() !== e) begin
                miscompares++;
                $display("FAIL ignore cyc=%0d got=%h exp=%h", cyc, act32(), e);
            end
            if (bus32.done === 1'b1) begin
                dones++;
                if (exp_q.size() != 0) begin
                    ep = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    vectors++;
                    if (prod_q !== ep || cyc != ec) begin
                        miscompares++;
                        $display("FAIL ignore_sb prod=%h exp=%h cyc=%0d exp=%0d", prod_q, ep, cyc, ec);
                    end
                end
            end
            bus32.start = (cyc == 12);
            tick();
        end
        bus32.start = 1'b0;
        vectors++;
        if (dones != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ignore_count dones=%0d exp=1 pending=%0d", dones, exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int found;
        found = 0;
        a_op = 64'd3;
        b_op = 32'h0000_0005;
        bus32.start = 1'b1;
        exp_q.push_back(64'd15);
        cyc_q.push_back(34);
        tick();
        bus32.start = 1'b0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            if (bus32.count === 6'd17 && bus32.busy === 1'b1) found = 1;
            else tick();
        end
        vectors++;
        if (found == 0) begin
            miscompares++;
            $display("FAIL rstmid_reach count=%0d exp=17", bus32.count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        vectors++;
        if (act32() !== IDLE_V) begin
            miscompares++;
            $display("FAIL rstmid_idle got=%h exp=%h", act32(), IDLE_V);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++;
            if (act32() !== IDLE_V) begin
                miscompares++;
                $display("FAIL rstmid_quiet i=%0d got=%h exp=%h", i, act32(), IDLE_V);
            end
        end
        reset = 1'b1;
        bus32.start = 1'b1;
        tick();
        reset = 1'b0;
        bus32.start = 1'b0;
        tick();
        vectors++;
        if (act32() !== IDLE_V) begin
            miscompares++;
            $display("FAIL rst_start_same got=%h exp=%h", act32(), IDLE_V);
        end
    endtask

    task automatic test_small();
        logic [11:0] e;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            b4_lsb = cyc[0];
            #1;
            if (cyc == 1) e = LOAD_V;
            else if (cyc <= 5) e = pk(1'b1, 1'b0, 6'(cyc - 2), 1'b1, 1'b1, 1'b1, !b4_lsb);
            else if (cyc == 6) e = DONE_V;
            else e = IDLE_V;
            vectors++;
            if (act4() !== e) begin
                miscompares++;
                $display("FAIL small cyc=%0d got=%h exp=%h", cyc, act4(), e);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus32.start = 1'b0;
        bus4.start = 1'b0;
        b4_lsb = 1'b0;
        a_op = 64'd0;
        b_op = 32'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiplicador_ctrl.md
# multiplicador_ctrl

Sequencing controller for the shift-add `multiplicador` datapath. It owns the other side of that datapath's control interface: it accepts a start request and samples `b_lsb` each cycle. It drives `a_sel`, `b_sel`, `prod_sel` and `add_sel` through one load cycle and `N_BITS` add/shift iterations, then pulses `done` while `prod` holds the result. It shares `clk`/`reset` with the datapath and sits between the datapath and any requesting logic.

## Interface
- `N_BITS`, default 32: number of add/shift iterations, equal to the operand width. Legal range 2..63.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  reset; synchronous and active-high.
- `start`  in  1  request a multiplication; sampled only in IDLE and DONE.
- `b_lsb`  in  1  datapath register-B bit 0; used combinationally.
- `a_sel`  out  1  0 = register A loads operand `a`; 1 = register A loads `A<<1`.
- `b_sel`  out  1  0 = register B loads operand `b`; 1 = register B loads the shifted B.
- `prod_sel`  out  1  0 = product register loads 0; 1 = product register loads the add/hold path.
- `add_sel`  out  1  0 = product register takes `A+prod`; 1 = product register holds `prod`.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  high for exactly one cycle in DONE.
- `count`  out  6  iteration index during RUN; 0 otherwise.

## Operation
- States: IDLE, LOAD, RUN, DONE. Encoding is free. `state`/`count` are registers; outputs decode from the state, plus `b_lsb` for `add_sel`.
- Reset: state IDLE, `count=0`, `busy=0`, `done=0`.
- IDLE
  - Outputs: `a_sel=0`, `b_sel=0`, `prod_sel=1`, `add_sel=1`. Operands track the inputs; `prod` holds.
  - `start=1` -> LOAD.
- LOAD
  - Outputs: `a_sel=0`, `b_sel=0`, `prod_sel=0`, `add_sel=1`.
  - At the closing edge, operands are captured and `prod` is cleared to 0.
  - Always -> RUN with `count=0`.
- RUN
  - Outputs: `a_sel=1`, `b_sel=1`, `prod_sel=1`, `add_sel=~b_lsb` (Mealy).
  - If `count==N_BITS-1` -> DONE with `count=0`; otherwise `count+1`.
- DONE
  - Outputs: same as IDLE, plus `done=1`.
  - `start=1` -> LOAD (back-to-back operation); otherwise -> IDLE.
- `start` in LOAD or RUN is ignored. There is no queuing and no restart.
- `b_lsb` is ignored outside RUN.
- `count` never exceeds `N_BITS-1`. It resets to 0 on leaving RUN.

## Timing
- Edge E0 samples `start=1` in IDLE. LOAD occupies the cycle after E0.
- RUN occupies the cycles after E1..E(N_BITS). The last add/shift commits at E(N_BITS+1).
- DONE is the cycle after E(N_BITS+1). `done=1` there and `prod` is final.
- Latency from start sample to `done`: N_BITS+2 cycles, i.e. 34 for N_BITS=32.
- Back-to-back throughput: one result every N_BITS+2 cycles.
- `busy` rises the cycle after E0 and falls the cycle `done` rises. `busy` and `done` are never high together.
- `add_sel` follows `b_lsb` in the same cycle, with no register stage. `b_lsb` must settle before the edge, within one cycle of combinational path.
- Reset mid-operation (any state, any `count`): at the reset edge go to IDLE, `count=0`, `done=0`, `busy=0`. No `done` pulse is emitted for the aborted operation.
- `reset` and `start` high on the same edge: reset wins and the start is lost.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset=1` for 2 cycles, release, `start=0` for 10 cycles.
  - Required: `busy=0`, `done=0`, `count=0`, `a_sel=0`, `b_sel=0`, `prod_sel=1`, `add_sel=1` throughout.
- Single run, N_BITS=32, `b_lsb` driven from a bench model of B = 0x00000005 shifting right:
  - Required: LOAD for 1 cycle with `prod_sel=0`.
  - `add_sel=0` only at `count=0` and `count=2`.
  - `done` pulses exactly 34 cycles after the start edge.
  - Integrated with the datapath model, prod = 3*5 = 0x000000000000000F.
- Back-to-back:
  - Stimulus: hold `start=1` continuously.
  - Required: `done` pulses every 34 cycles; LOAD directly follows DONE with no IDLE cycle.
- Start ignored while busy:
  - Stimulus: pulse `start` at `count=10`.
  - Required: sequence unchanged; exactly one `done`, at cycle 34.
- Reset mid-run:
  - Stimulus: assert `reset` at `count=17`.
  - Required: next cycle in IDLE, `count=0`, `busy=0`, and no `done` within 40 subsequent cycles.
- Small parameter, N_BITS=4:
  - Required: `count` runs 0..3 and `done` arrives 6 cycles after start.
